// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the layer-2 scheduler state encoding.
package cnn_pkg;

  localparam int IMG_DIM = 13;
  localparam int WIN     = 4;
  localparam int STRIDE  = 3;
  localparam int OUT_DIM = 4;
  localparam int TAPS    = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    CLR,
    MAC,
    WRITE,
    DONE
  } l2_state_t;

endpackage

// File: rtl/l2_addr_gen.sv
// Feature-buffer address for tap k of the 4x4 window at output position (ox, oy).
module l2_addr_gen
  import cnn_pkg::*;
(
  input  logic [1:0] ox,
  input  logic [1:0] oy,
  input  logic [3:0] k,
  output logic [7:0] buf_adr
);

  logic [7:0] row;
  logic [7:0] col;

  // Window origin sits at (3*oy, 3*ox); the tap adds (k/4, k%4). Peak is 12*13+12 = 168.
  assign row     = 8'(STRIDE) * {6'b0, oy} + {6'b0, k[3:2]};
  assign col     = 8'(STRIDE) * {6'b0, ox} + {6'b0, k[1:0]};
  assign buf_adr = row * 8'(IMG_DIM) + col;

endmodule

// File: rtl/cnn_l2_sched.sv
// Layer-2 scheduler: fetches each 4x4 window once, then runs one MAC pass and
// one OFM write per kernel filter, stepping the window over a 4x4 output grid.
module cnn_l2_sched
  import cnn_pkg::*;
#(
  parameter  int N  = 2,
  localparam int FW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ofm_ready,
  output logic          busy,
  output logic          done,
  output logic          buf_rd,
  output logic [7:0]    buf_adr,
  output logic [15:0]   win_en,
  output logic          mac_rst,
  output logic          mac_en,
  output logic [3:0]    mac_tap,
  output logic [FW-1:0] kernel_sel,
  output logic          ofm_wr,
  output logic [31:0]   ofm_adr
);

  localparam logic [3:0]    K_LAST = 4'(TAPS - 1);
  localparam logic [1:0]    P_LAST = 2'(OUT_DIM - 1);
  localparam logic [FW-1:0] F_LAST = FW'(N - 1);

  l2_state_t     state, state_nxt;
  logic [3:0]    k, k_nxt;
  logic [FW-1:0] f, f_nxt;
  logic [1:0]    ox, ox_nxt;
  logic [1:0]    oy, oy_nxt;

  logic [7:0]    adr_nxt;
  logic          busy_d, done_d, buf_rd_d, mac_rst_d, mac_en_d, ofm_wr_d;
  logic [7:0]    buf_adr_d;
  logic [15:0]   win_en_d;
  logic [3:0]    mac_tap_d;
  logic [FW-1:0] kernel_sel_d;
  logic [31:0]   ofm_adr_d;

  l2_addr_gen u_addr_gen (
    .ox      (ox_nxt),
    .oy      (oy_nxt),
    .k       (k_nxt),
    .buf_adr (adr_nxt)
  );

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    f_nxt     = f;
    ox_nxt    = ox;
    oy_nxt    = oy;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          k_nxt     = '0;
          f_nxt     = '0;
          ox_nxt    = '0;
          oy_nxt    = '0;
        end
      end
      FETCH: begin
        if (k == K_LAST) begin
          state_nxt = DRAIN;
          k_nxt     = '0;
        end else begin
          k_nxt = k + 4'd1;
        end
      end
      DRAIN: state_nxt = CLR;
      CLR: begin
        state_nxt = MAC;
        k_nxt     = '0;
      end
      MAC: begin
        if (k == K_LAST) begin
          state_nxt = WRITE;
          k_nxt     = '0;
        end else begin
          k_nxt = k + 4'd1;
        end
      end
      // Only an accepted write moves the FSM; a stall leaves every counter untouched.
      WRITE: begin
        if (ofm_ready) begin
          if (f != F_LAST) begin
            f_nxt     = f + FW'(1);
            state_nxt = CLR;
          end else if (ox == P_LAST && oy == P_LAST) begin
            state_nxt = DONE;
          end else begin
            f_nxt     = '0;
            k_nxt     = '0;
            state_nxt = FETCH;
            if (ox == P_LAST) begin
              ox_nxt = '0;
              oy_nxt = oy + 2'd1;
            end else begin
              ox_nxt = ox + 2'd1;
            end
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        k_nxt     = '0;
        f_nxt     = '0;
        ox_nxt    = '0;
        oy_nxt    = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without a cycle of lag.
  always_comb begin
    busy_d       = 1'b0;
    done_d       = 1'b0;
    buf_rd_d     = 1'b0;
    buf_adr_d    = '0;
    win_en_d     = '0;
    mac_rst_d    = 1'b0;
    mac_en_d     = 1'b0;
    mac_tap_d    = '0;
    kernel_sel_d = '0;
    ofm_wr_d     = 1'b0;
    ofm_adr_d    = '0;
    busy_d = state_nxt inside {FETCH, DRAIN, CLR, MAC, WRITE};
    case (state_nxt)
      FETCH: begin
        buf_rd_d  = 1'b1;
        buf_adr_d = adr_nxt;
        if (k_nxt != 4'd0) win_en_d = 16'd1 << (k_nxt - 4'd1);
      end
      DRAIN: win_en_d = 16'h8000;
      CLR: begin
        mac_rst_d    = 1'b1;
        kernel_sel_d = f_nxt;
      end
      MAC: begin
        mac_en_d     = 1'b1;
        mac_tap_d    = k_nxt;
        kernel_sel_d = f_nxt;
      end
      WRITE: begin
        ofm_wr_d     = 1'b1;
        kernel_sel_d = f_nxt;
        ofm_adr_d    = 32'(f_nxt) * 32'd16 + 32'(oy_nxt) * 32'd4 + 32'(ox_nxt);
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      f          <= '0;
      ox         <= '0;
      oy         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      buf_rd     <= 1'b0;
      buf_adr    <= '0;
      win_en     <= '0;
      mac_rst    <= 1'b0;
      mac_en     <= 1'b0;
      mac_tap    <= '0;
      kernel_sel <= '0;
      ofm_wr     <= 1'b0;
      ofm_adr    <= '0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      f          <= f_nxt;
      ox         <= ox_nxt;
      oy         <= oy_nxt;
      busy       <= busy_d;
      done       <= done_d;
      buf_rd     <= buf_rd_d;
      buf_adr    <= buf_adr_d;
      win_en     <= win_en_d;
      mac_rst    <= mac_rst_d;
      mac_en     <= mac_en_d;
      mac_tap    <= mac_tap_d;
      kernel_sel <= kernel_sel_d;
      ofm_wr     <= ofm_wr_d;
      ofm_adr    <= ofm_adr_d;
    end
  end

endmodule

// File: tb/tb_cnn_l2_sched.sv
// Directed bench for cnn_l2_sched (N=2): per-cycle capture of a pass compared
// against hand-computed windows, writes and latencies.
module tb_cnn_l2_sched;

  localparam int N  = 2;
  localparam int FW = 1;

  logic          clk = 1'b0;
  logic          rst_n, start, ofm_ready;
  logic          busy, done, buf_rd, mac_rst, mac_en, ofm_wr;
  logic [7:0]    buf_adr;
  logic [15:0]   win_en;
  logic [3:0]    mac_tap;
  logic [FW-1:0] kernel_sel;
  logic [31:0]   ofm_adr;

  always #5 clk = ~clk;

  cnn_l2_sched #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ofm_ready  (ofm_ready),
    .busy       (busy),
    .done       (done),
    .buf_rd     (buf_rd),
    .buf_adr    (buf_adr),
    .win_en     (win_en),
    .mac_rst    (mac_rst),
    .mac_en     (mac_en),
    .mac_tap    (mac_tap),
    .kernel_sel (kernel_sel),
    .ofm_wr     (ofm_wr),
    .ofm_adr    (ofm_adr)
  );

  typedef struct {
    logic          buf_rd;
    logic [15:0]   win_en;
    logic          mac_rst;
    logic          mac_en;
    logic [3:0]    mac_tap;
    logic [FW-1:0] kernel_sel;
    logic          ofm_wr;
    logic          busy;
  } snap_t;

  typedef struct {
    int pos;
    int first_adr;
    int last_adr;
    int wr0;
    int wr1;
  } vec_t;

  int    asserts  = 0;
  int    failures = 0;
  int    fetch_log [256];
  int    fetch_n;
  int    wr_log [64];
  int    wr_n;
  snap_t snap [64];
  logic  busy_at_done;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    asserts++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [35:0] outBits();
    return {busy, done, buf_rd, buf_adr, win_en, mac_rst, mac_en, mac_tap,
            kernel_sel, ofm_wr, |ofm_adr};
  endfunction

  function automatic int modelAdr(input int p, input int k);
    return (3 * (p / 4) + k / 4) * 13 + 3 * (p % 4) + k % 4;
  endfunction

  task automatic applyStimulus(input int stalls, input int restart_at, input bit abort,
                               output int done_cyc, output bit aborted);
    int cyc;
    int stall_cnt;
    for (int i = 0; i < 256; i++) fetch_log[i] = -1;
    for (int i = 0; i < 64; i++) wr_log[i] = -1;
    fetch_n      = 0;
    wr_n         = 0;
    cyc          = 0;
    stall_cnt    = 0;
    done_cyc     = -1;
    aborted      = 1'b0;
    busy_at_done = 1'b1;
    @(negedge clk);
    ofm_ready = (stalls == 0);
    start     = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (restart_at > 0 && cyc == restart_at) start = 1'b1;
      if (restart_at > 0 && cyc == restart_at + 1) start = 1'b0;
      if (cyc < 64)
        snap[cyc] = '{buf_rd, win_en, mac_rst, mac_en, mac_tap, kernel_sel, ofm_wr, busy};
      if (buf_rd && fetch_n < 256) begin
        fetch_log[fetch_n] = int'(buf_adr);
        fetch_n++;
      end
      if (stalls > 0 && stall_cnt <= stalls && (ofm_wr || stall_cnt > 0)) begin
        if (stall_cnt < stalls) begin
          checkOutput("stall ofm_wr", ofm_wr, 1);
          checkOutput("stall ofm_adr", ofm_adr, 0);
          checkOutput("stall mac_en", mac_en, 0);
        end else begin
          ofm_ready = 1'b1;
        end
        stall_cnt++;
      end
      if (ofm_wr && ofm_ready && wr_n < 64) begin
        wr_log[wr_n] = int'(ofm_adr);
        wr_n++;
      end
      if (abort && wr_n == 10 && mac_en) begin
        aborted = 1'b1;
        break;
      end
      if (done) begin
        done_cyc     = cyc;
        busy_at_done = busy;
        break;
      end
    end
    if (!aborted && done_cyc < 0) checkOutput("done within cycle budget", cyc, 849);
  endtask

  vec_t vecs [5];
  int   done_cyc;
  bit   aborted;
  int   bad;

  initial begin
    vecs[0] = '{0,    0,  42, 0, 16};
    vecs[1] = '{1,    3,  45, 1, 17};
    vecs[2] = '{6,   45,  87, 6, 22};
    vecs[3] = '{8,   78, 120, 8, 24};
    vecs[4] = '{15, 126, 168, 15, 31};

    rst_n     = 1'b0;
    start     = 1'b0;
    ofm_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset buf_rd", buf_rd, 0);
    checkOutput("reset win_en", win_en, 0);
    checkOutput("reset ofm_wr", ofm_wr, 0);
    checkOutput("reset all outputs", outBits(), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle after release", outBits(), 0);

    // Nominal pass with the OFM always ready.
    applyStimulus(0, 0, 1'b0, done_cyc, aborted);
    checkOutput("nominal done cycle", done_cyc, 849);
    checkOutput("busy low at done", busy_at_done, 0);
    checkOutput("nominal write count", wr_n, 32);
    checkOutput("nominal fetch count", fetch_n, 256);
    checkOutput("cycle1 buf_rd", snap[1].buf_rd, 1);
    checkOutput("cycle1 busy", snap[1].busy, 1);
    checkOutput("cycle1 win_en", snap[1].win_en, 0);
    checkOutput("cycle2 win_en", snap[2].win_en, 16'h0001);
    checkOutput("cycle16 win_en", snap[16].win_en, 16'h4000);
    checkOutput("drain win_en", snap[17].win_en, 16'h8000);
    checkOutput("drain buf_rd", snap[17].buf_rd, 0);
    checkOutput("clr mac_rst", snap[18].mac_rst, 1);
    checkOutput("mac first tap en", snap[19].mac_en, 1);
    checkOutput("mac last tap", snap[34].mac_tap, 15);
    checkOutput("first write ofm_wr", snap[35].ofm_wr, 1);
    checkOutput("write mac_en", snap[35].mac_en, 0);
    checkOutput("second clr mac_rst", snap[36].mac_rst, 1);
    checkOutput("second filter kernel_sel", snap[37].kernel_sel, 1);
    checkOutput("first filter kernel_sel", snap[20].kernel_sel, 0);
    checkOutput("next position buf_rd", snap[54].buf_rd, 1);
    checkOutput("first window tap4", fetch_log[4], 13);
    checkOutput("first window tap8", fetch_log[8], 26);
    bad = 0;
    for (int p = 0; p < 16; p++)
      for (int k = 0; k < 16; k++)
        if (fetch_log[p * 16 + k] != modelAdr(p, k)) bad++;
    checkOutput("fetch address mismatches", bad, 0);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (wr_log[i] != (i % 2) * 16 + i / 2) bad++;
    checkOutput("write address mismatches", bad, 0);
    for (int v = 0; v < 5; v++) begin
      checkOutput($sformatf("pos%0d first adr", vecs[v].pos), fetch_log[vecs[v].pos * 16], vecs[v].first_adr);
      checkOutput($sformatf("pos%0d last adr", vecs[v].pos), fetch_log[vecs[v].pos * 16 + 15], vecs[v].last_adr);
      checkOutput($sformatf("pos%0d write0", vecs[v].pos), wr_log[vecs[v].pos * 2], vecs[v].wr0);
      checkOutput($sformatf("pos%0d write1", vecs[v].pos), wr_log[vecs[v].pos * 2 + 1], vecs[v].wr1);
    end
    @(negedge clk);
    checkOutput("idle after done", outBits(), 0);

    // Five cycles of OFM backpressure on the very first write.
    applyStimulus(5, 0, 1'b0, done_cyc, aborted);
    checkOutput("stalled done cycle", done_cyc, 854);
    checkOutput("stalled write count", wr_n, 32);
    checkOutput("stalled first write adr", wr_log[0], 0);

    // A second start in the middle of a pass must be ignored.
    ofm_ready = 1'b1;
    applyStimulus(0, 100, 1'b0, done_cyc, aborted);
    checkOutput("restart done cycle", done_cyc, 849);
    checkOutput("restart write count", wr_n, 32);
    repeat (3) @(negedge clk);
    checkOutput("no second pass", outBits(), 0);

    // Reset in the MAC phase of position 5, then a fresh pass.
    applyStimulus(0, 0, 1'b1, done_cyc, aborted);
    checkOutput("reached position 5 mac", aborted, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset clears outputs", outBits(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (ofm_wr || buf_rd || busy) bad++;
    end
    checkOutput("quiet after reset release", bad, 0);
    applyStimulus(0, 0, 1'b0, done_cyc, aborted);
    checkOutput("post-reset first adr", fetch_log[0], 0);
    checkOutput("post-reset write count", wr_n, 32);
    checkOutput("post-reset done cycle", done_cyc, 849);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
